// File: rtl/qick_xcom_pkg.sv
// Shared types for the xcom command arbiter: handshake FSM states, opcode
// field positions and the per-entry command header stored in the queue.
package qick_xcom_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } xcom_state_t;

    localparam int OP_W       = 8;
    localparam int OP_LOC_BIT = 7;
    localparam int SRC_W      = 3;

    // Queue entry header; the DW-bit data word is appended below it in the FIFO.
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [SRC_W-1:0] src;
    } xcom_cmd_t;

    function automatic logic op_is_local(input logic [OP_W-1:0] op);
        return op[OP_LOC_BIT];
    endfunction

endpackage

// File: rtl/qick_xcom_sfifo.sv
// Synchronous FIFO with flush; push is ignored when full, pop when empty,
// and flush takes priority over both.
module qick_xcom_sfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/qick_xcom_cmd_arb.sv
// Multi-source command arbiter: grants one source into a shared queue and
// issues the queue head over a 4-phase local or network handshake.
module qick_xcom_cmd_arb
    import qick_xcom_pkg::*;
#(
    parameter int NSRC  = 2,
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int RR    = 1
) (
    input  logic                   c_clk_i,
    input  logic                   c_rst_i,
    input  logic                   flush_i,
    input  logic [NSRC-1:0]        src_vld_i,
    input  logic [NSRC*8-1:0]      src_op_i,
    input  logic [NSRC*DW-1:0]     src_dt_i,
    output logic [NSRC-1:0]        src_rdy_o,
    output logic                   cmd_loc_req_o,
    input  logic                   cmd_loc_ack_i,
    output logic                   cmd_net_req_o,
    input  logic                   cmd_net_ack_i,
    output logic [7:0]             cmd_op_o,
    output logic [DW-1:0]          cmd_dt_o,
    output logic [2:0]             cmd_src_o,
    output logic [7:0]             cmd_cnt_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   busy_o
);

    localparam int EW = $bits(xcom_cmd_t) + DW;

    xcom_state_t      state;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] gnt_idx;
    logic             gnt_found;
    int               idx;
    logic             push;
    logic             pop;
    logic             sel_ack;
    logic             fifo_full;
    logic             fifo_empty;
    xcom_cmd_t        push_cmd;
    xcom_cmd_t        head_cmd;
    logic [DW-1:0]    push_dt;
    logic [DW-1:0]    head_dt;
    logic [EW-1:0]    head_entry;

    // Search order starts after the last granted source in round-robin mode.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NSRC; k++) begin
            idx = (RR != 0) ? ((int'(rr_ptr) + 1 + k) % NSRC) : k;
            for (int j = 0; j < NSRC; j++) begin
                if (j == idx && src_vld_i[j] && !gnt_found) begin
                    gnt_found = 1'b1;
                    gnt_idx   = SRC_W'(j);
                end
            end
        end
    end

    assign push = gnt_found && !fifo_full && !flush_i;

    always_comb begin
        src_rdy_o    = '0;
        push_cmd     = '0;
        push_dt      = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (gnt_idx == SRC_W'(i)) begin
                src_rdy_o[i] = push;
                push_cmd.op  = src_op_i[OP_W*i +: OP_W];
                push_dt      = src_dt_i[DW*i +: DW];
            end
        end
        push_cmd.src = gnt_idx;
    end

    always_ff @(posedge c_clk_i) begin
        if (c_rst_i) begin
            rr_ptr <= SRC_W'(NSRC - 1);
        end else if (push) begin
            rr_ptr <= gnt_idx;
        end
    end

    qick_xcom_sfifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (c_clk_i),
        .rst   (c_rst_i),
        .push  (push),
        .din   ({push_cmd, push_dt}),
        .pop   (pop),
        .flush (flush_i),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    assign {head_cmd, head_dt} = head_entry;

    // The issued opcode is held through REQ/REL, so it selects the ack to watch.
    assign sel_ack = op_is_local(cmd_op_o) ? cmd_loc_ack_i : cmd_net_ack_i;
    assign pop     = (state == ST_REQ) && sel_ack;
    assign busy_o  = (level_o != '0) || (state != ST_IDLE);

    always_ff @(posedge c_clk_i) begin
        if (c_rst_i) begin
            state         <= ST_IDLE;
            cmd_op_o      <= '0;
            cmd_dt_o      <= '0;
            cmd_src_o     <= '0;
            cmd_loc_req_o <= 1'b0;
            cmd_net_req_o <= 1'b0;
            cmd_cnt_o     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cmd_op_o      <= head_cmd.op;
                        cmd_dt_o      <= head_dt;
                        cmd_src_o     <= head_cmd.src;
                        cmd_loc_req_o <= op_is_local(head_cmd.op);
                        cmd_net_req_o <= !op_is_local(head_cmd.op);
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sel_ack) begin
                        cmd_loc_req_o <= 1'b0;
                        cmd_net_req_o <= 1'b0;
                        cmd_cnt_o     <= cmd_cnt_o + 8'd1;
                        state         <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (!sel_ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qick_xcom_cmd_arb.sv
// Bench for qick_xcom_cmd_arb: a round-robin instance checked cycle by cycle
// against a queue-based reference model, plus a fixed-priority instance.
module tb_qick_xcom_cmd_arb;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;

    logic        flush = 1'b0;
    logic [1:0]  src_vld = '0;
    logic [15:0] src_op = '0;
    logic [63:0] src_dt = '0;
    logic [1:0]  src_rdy;
    logic        loc_req, net_req;
    logic        loc_ack = 1'b0, net_ack = 1'b0;
    logic [7:0]  cmd_op;
    logic [31:0] cmd_dt;
    logic [2:0]  cmd_src;
    logic [7:0]  cmd_cnt;
    logic [2:0]  level;
    logic        busy;

    logic        fp_flush = 1'b0;
    logic [2:0]  fp_vld = '0;
    logic [23:0] fp_op = '0;
    logic [95:0] fp_dt = '0;
    logic [2:0]  fp_rdy;
    logic        fp_loc_req, fp_net_req;
    logic        fp_loc_ack = 1'b0, fp_net_ack = 1'b0;
    logic [7:0]  fp_cmd_op;
    logic [31:0] fp_cmd_dt;
    logic [2:0]  fp_cmd_src;
    logic [7:0]  fp_cmd_cnt;
    logic [2:0]  fp_level;
    logic        fp_busy;

    qick_xcom_cmd_arb #(.NSRC(2), .DEPTH(DEPTH), .DW(DW), .RR(1)) dut (
        .c_clk_i(clk), .c_rst_i(rst), .flush_i(flush),
        .src_vld_i(src_vld), .src_op_i(src_op), .src_dt_i(src_dt), .src_rdy_o(src_rdy),
        .cmd_loc_req_o(loc_req), .cmd_loc_ack_i(loc_ack),
        .cmd_net_req_o(net_req), .cmd_net_ack_i(net_ack),
        .cmd_op_o(cmd_op), .cmd_dt_o(cmd_dt), .cmd_src_o(cmd_src),
        .cmd_cnt_o(cmd_cnt), .level_o(level), .busy_o(busy)
    );

    qick_xcom_cmd_arb #(.NSRC(3), .DEPTH(DEPTH), .DW(DW), .RR(0)) dut_fp (
        .c_clk_i(clk), .c_rst_i(rst), .flush_i(fp_flush),
        .src_vld_i(fp_vld), .src_op_i(fp_op), .src_dt_i(fp_dt), .src_rdy_o(fp_rdy),
        .cmd_loc_req_o(fp_loc_req), .cmd_loc_ack_i(fp_loc_ack),
        .cmd_net_req_o(fp_net_req), .cmd_net_ack_i(fp_net_ack),
        .cmd_op_o(fp_cmd_op), .cmd_dt_o(fp_cmd_dt), .cmd_src_o(fp_cmd_src),
        .cmd_cnt_o(fp_cmd_cnt), .level_o(fp_level), .busy_o(fp_busy)
    );

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] dt;
        logic [2:0]  src;
    } model_cmd_t;

    // Reference model: pending commands in order, plus the in-flight handshake.
    model_cmd_t  q[$];
    bit          m_req, m_rel;
    logic [7:0]  m_op;
    logic [31:0] m_dt;
    logic [2:0]  m_src;
    int          m_cnt;
    int          m_last;

    int          n_cmp = 0;
    int          n_err = 0;
    int          src_seen[$];

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int rrGrant(input logic [1:0] v, input int last);
        for (int k = 0; k < 2; k++) begin
            int i;
            i = (last + 1 + k) % 2;
            if (v[i[0]]) return i;
        end
        return -1;
    endfunction

    task automatic modelReset();
        q.delete();
        m_req  = 0;
        m_rel  = 0;
        m_op   = '0;
        m_dt   = '0;
        m_src  = '0;
        m_cnt  = 0;
        m_last = 1;
    endtask

    // One clock cycle: drive, check against the model, then advance the model.
    task automatic applyStimulus(input logic [1:0] v, input logic [15:0] ops,
                                 input logic fl, input logic al, input logic an);
        int         g;
        bit         acc, ack;
        logic [1:0] exp_rdy;
        model_cmd_t c;
        @(negedge clk);
        src_vld = v;
        src_op  = ops;
        src_dt  = {$urandom, $urandom};
        flush   = fl;
        loc_ack = al;
        net_ack = an;
        #1;
        g   = rrGrant(v, m_last);
        acc = (g >= 0) && (q.size() < DEPTH) && !fl;
        exp_rdy = 2'b00;
        if (acc) exp_rdy[g[0]] = 1'b1;
        checkOutput("src_rdy", 64'(src_rdy), 64'(exp_rdy));
        checkOutput("loc_req", 64'(loc_req), 64'(m_req && m_op[7]));
        checkOutput("net_req", 64'(net_req), 64'(m_req && !m_op[7]));
        checkOutput("cmd_op", 64'(cmd_op), 64'(m_op));
        checkOutput("cmd_dt", 64'(cmd_dt), 64'(m_dt));
        checkOutput("cmd_src", 64'(cmd_src), 64'(m_src));
        checkOutput("level", 64'(level), 64'(q.size()));
        checkOutput("cmd_cnt", 64'(cmd_cnt), 64'(m_cnt));
        checkOutput("busy", 64'(busy), 64'(q.size() != 0 || m_req || m_rel));

        ack = m_op[7] ? al : an;
        if (m_req) begin
            if (ack) begin
                m_req = 0;
                m_rel = 1;
                m_cnt = (m_cnt + 1) % 256;
                if (q.size() > 0 && !fl) void'(q.pop_front());
            end
        end else if (m_rel) begin
            if (!ack) m_rel = 0;
        end else if (q.size() > 0) begin
            m_req = 1;
            m_op  = q[0].op;
            m_dt  = q[0].dt;
            m_src = q[0].src;
        end
        if (fl) begin
            q.delete();
        end else if (acc) begin
            c.op   = ops[8*g +: 8];
            c.dt   = src_dt[32*g +: 32];
            c.src  = 3'(g);
            m_last = g;
            q.push_back(c);
        end
    endtask

    task automatic doReset(input logic ack_lvl);
        @(negedge clk);
        rst     = 1'b1;
        src_vld = '0;
        fp_vld  = '0;
        flush   = 1'b0;
        loc_ack = ack_lvl;
        net_ack = ack_lvl;
        @(negedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    // Answer every request until the queue and handshake are idle.
    task automatic drain();
        bit prev_req = 0;
        bit cur_req;
        int n = 0;
        while ((q.size() != 0 || m_req || m_rel) && n < 200) begin
            applyStimulus(2'b00, 16'h0, 1'b0, m_req, m_req);
            cur_req = loc_req || net_req;
            if (cur_req && !prev_req) src_seen.push_back(int'(cmd_src));
            prev_req = cur_req;
            n++;
        end
        if (n >= 200) checkOutput("drain_timeout", 64'(1), 64'(0));
    endtask

    task automatic runOne();
        int n = 0;
        applyStimulus(2'b01, 16'($urandom), 1'b0, 1'b0, 1'b0);
        do begin
            applyStimulus(2'b00, 16'h0, 1'b0, m_req, m_req);
            n++;
        end while ((q.size() != 0 || m_req || m_rel) && n < 10);
        if (n >= 10) checkOutput("handshake_timeout", 64'(1), 64'(0));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            fp_loc_ack = fp_loc_req;
            fp_net_ack = fp_net_req;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt0;
        int n0, n2;
        int exp_src[4];
        modelReset();
        doReset(1'b0);

        checkOutput("rst_level", 64'(level), 64'(0));
        checkOutput("rst_cnt", 64'(cmd_cnt), 64'(0));
        checkOutput("rst_loc_req", 64'(loc_req), 64'(0));
        checkOutput("rst_net_req", 64'(net_req), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_op", 64'(cmd_op), 64'(0));
        checkOutput("rst_src", 64'(cmd_src), 64'(0));

        // Both sources valid, acks low: alternating grants, then full.
        applyStimulus(2'b11, 16'($urandom), 1'b0, 1'b0, 1'b0);
        checkOutput("rr_grant0", 64'(src_rdy), 64'(2'b01));
        applyStimulus(2'b11, 16'($urandom), 1'b0, 1'b0, 1'b0);
        checkOutput("rr_grant1", 64'(src_rdy), 64'(2'b10));
        applyStimulus(2'b11, 16'($urandom), 1'b0, 1'b0, 1'b0);
        checkOutput("rr_grant2", 64'(src_rdy), 64'(2'b01));
        applyStimulus(2'b11, 16'($urandom), 1'b0, 1'b0, 1'b0);
        checkOutput("rr_grant3", 64'(src_rdy), 64'(2'b10));
        applyStimulus(2'b11, 16'($urandom), 1'b0, 1'b0, 1'b0);
        checkOutput("full_fifth_blocked", 64'(src_rdy), 64'(2'b00));
        checkOutput("full_level", 64'(level), 64'(4));
        applyStimulus(2'b11, 16'($urandom), 1'b0, 1'b1, 1'b1);
        checkOutput("full_pop_no_grant", 64'(src_rdy), 64'(2'b00));
        applyStimulus(2'b11, 16'($urandom), 1'b0, 1'b0, 1'b0);
        checkOutput("fifth_accepted", 64'(src_rdy), 64'(2'b01));
        src_seen.delete();
        drain();
        exp_src = '{1, 0, 1, 0};
        checkOutput("src_order_len", 64'(src_seen.size()), 64'(4));
        for (int k = 0; k < 4 && k < src_seen.size(); k++)
            checkOutput($sformatf("src_order%0d", k), 64'(src_seen[k]), 64'(exp_src[k]));

        // Local opcode into an empty queue.
        doReset(1'b0);
        applyStimulus(2'b01, 16'h0085, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("loc_req_edge1", 64'(loc_req), 64'(0));
        applyStimulus(2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("loc_req_edge2", 64'(loc_req), 64'(1));
        checkOutput("net_req_edge2", 64'(net_req), 64'(0));
        checkOutput("op_85", 64'(cmd_op), 64'(8'h85));
        applyStimulus(2'b00, 16'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("single_cnt", 64'(cmd_cnt), 64'(1));
        checkOutput("single_busy", 64'(busy), 64'(0));

        // Flush during REQ with three queued.
        cnt0 = int'(cmd_cnt);
        for (int k = 0; k < 3; k++) applyStimulus(2'b01, 16'h0081, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 16'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_level", 64'(level), 64'(0));
        checkOutput("flush_req_kept", 64'(loc_req), 64'(1));
        applyStimulus(2'b00, 16'h0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_cnt", 64'(cmd_cnt), 64'((cnt0 + 1) % 256));
        checkOutput("flush_level_after", 64'(level), 64'(0));
        checkOutput("flush_busy", 64'(busy), 64'(0));

        // Counter wrap.
        doReset(1'b0);
        for (int k = 0; k < 255; k++) runOne();
        checkOutput("cnt_255", 64'(cmd_cnt), 64'(255));
        runOne();
        checkOutput("cnt_wrap", 64'(cmd_cnt), 64'(0));

        // Reset while a request is up.
        applyStimulus(2'b01, 16'h0001, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_rst_net_req", 64'(net_req), 64'(1));
        doReset(1'b1);
        checkOutput("rst_req_loc", 64'(loc_req), 64'(0));
        checkOutput("rst_req_net", 64'(net_req), 64'(0));
        checkOutput("rst_req_cnt", 64'(cmd_cnt), 64'(0));

        // Random traffic with flushes and noisy acks.
        for (int k = 0; k < 1500; k++)
            applyStimulus(2'($urandom), 16'($urandom), ($urandom_range(0, 15) == 0),
                          1'($urandom), 1'($urandom));
        drain();

        // Fixed priority: source 0 always beats source 2.
        n0 = 0;
        n2 = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            fp_vld = 3'b101;
            fp_op  = 24'($urandom);
            fp_dt  = {$urandom, $urandom, $urandom};
            #1;
            if (fp_rdy != 3'b000) begin
                checkOutput("fp_grant_src0", 64'(fp_rdy), 64'(3'b001));
                n0++;
            end
            if (fp_loc_req || fp_net_req) checkOutput("fp_cmd_src0", 64'(fp_cmd_src), 64'(0));
        end
        checkOutput("fp_src0_served", 64'(n0 > 0), 64'(1));
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            fp_vld = 3'b100;
            fp_op  = 24'($urandom);
            #1;
            if (fp_rdy != 3'b000) begin
                checkOutput("fp_grant_src2", 64'(fp_rdy), 64'(3'b100));
                n2++;
            end
        end
        checkOutput("fp_src2_served", 64'(n2 > 0), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qick_xcom_cmd_arb.md
QICK_XCOM_CMD_ARB -- requirements
Module: qick_xcom_cmd_arb

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NSRC, default 2, SHALL set the number of command sources (1..8).
REQ-003 Parameter DEPTH, default 4, SHALL set the queue entries (power of 2, 2..16).
REQ-004 Parameter DW, default 32, SHALL set the command data width.
REQ-005 Parameter RR, default 1, SHALL select arbitration: 1 = round-robin, 0 = fixed priority (lowest index wins).
REQ-006 Ports SHALL be:
c_clk_i  in  1  clock
c_rst_i  in  1  synchronous active-high reset
flush_i  in  1  discard all queued, not-yet-issued commands
src_vld_i  in  NSRC  per-source command valid
src_op_i  in  NSRC*8  per-source opcode, source i at [8i+7:8i]
src_dt_i  in  NSRC*DW  per-source data, source i at [DW*i+DW-1:DW*i]
src_rdy_o  out  NSRC  per-source accept (one-hot or zero)
cmd_loc_req_o  out  1  local command request
cmd_loc_ack_i  in  1  local command acknowledge
cmd_net_req_o  out  1  network command request
cmd_net_ack_i  in  1  network command acknowledge
cmd_op_o  out  8  issued opcode
cmd_dt_o  out  DW  issued data
cmd_src_o  out  3  index of the issuing source
cmd_cnt_o  out  8  completed-command counter
level_o  out  clog2(DEPTH)+1  queue occupancy
busy_o  out  1  queue non-empty or handshake in progress

Function
REQ-007 src_rdy_o[i] SHALL be combinational and high only for the granted source, and only while the queue is not full and flush_i is low.
REQ-008 A command SHALL be accepted on the edge where src_vld_i[i] and src_rdy_o[i] are both high; {op, dt, i} SHALL be written to the queue tail.
REQ-009 With RR=0, the grant SHALL go to the lowest valid index.
REQ-010 With RR=1, the search SHALL start at (last granted + 1) mod NSRC; the pointer SHALL update only on acceptance and SHALL reset to NSRC-1.
REQ-011 When the queue is full, no source SHALL be granted, even if a pop occurs in the same cycle.
REQ-012 The output FSM SHALL have the states IDLE, REQ and REL.
REQ-013 IDLE -> REQ SHALL occur when the queue is non-empty; the head entry SHALL be registered onto cmd_op_o/cmd_dt_o/cmd_src_o, and cmd_loc_req_o (op[7]=1) or cmd_net_req_o (op[7]=0) SHALL be set.
REQ-014 The request SHALL rise two clock edges after acceptance into an empty queue while the FSM is IDLE.
REQ-015 In REQ, cmd_op_o/cmd_dt_o SHALL stay stable; on the selected ack being high, the FSM SHALL clear the request, pop the head, increment cmd_cnt_o, and go to REL.
REQ-016 In REL, the FSM SHALL return to IDLE when the selected ack is low (4-phase handshake); the non-selected ack SHALL be ignored.
REQ-017 cmd_cnt_o SHALL wrap 255 -> 0.
REQ-018 level_o SHALL equal pushes minus pops and range 0..DEPTH.
REQ-019 A simultaneous push and pop (not full) SHALL leave level_o unchanged.
REQ-020 flush_i SHALL empty the queue on the next edge.
REQ-021 flush_i SHALL NOT abort an in-flight REQ/REL handshake; a pop from that handshake after the flush SHALL NOT underflow.
REQ-022 busy_o SHALL equal (level_o != 0) or (state != IDLE).

Reset
REQ-023 On reset: the FSM SHALL go to IDLE; queue pointers, level_o, cmd_cnt_o, cmd_op_o, cmd_dt_o and cmd_src_o SHALL be 0; both requests SHALL be low; the RR pointer SHALL be NSRC-1.
REQ-024 A reset during REQ SHALL drop the request on the next edge with no counter increment.

Structure
REQ-025 A shared package qick_xcom_pkg SHALL hold the FSM state enum, the opcode field positions (bit 7 = local) and the queue entry struct.
REQ-026 The queue SHALL be one sub-module, qick_xcom_sfifo (synchronous FIFO, parameters DEPTH and width, with push/pop/flush/full/empty/level).

Verification
REQ-027 The bench SHALL cover: NSRC=2, RR=1, both sources valid continuously -> grants alternate 0,1,0,1; cmd_src_o follows the same order.
REQ-028 The bench SHALL cover: RR=0, sources 0 and 2 valid -> source 0 is always granted; source 2 is granted only after src_vld_i[0] drops.
REQ-029 The bench SHALL cover: DEPTH=4, acks held low, five pushes -> four are accepted, level_o=4, the fifth src_rdy_o stays low; after one ack/release, the fifth is accepted.
REQ-030 The bench SHALL cover: op=0x85 pushed into an empty queue -> cmd_loc_req_o high two edges later, net req low; ack, then release -> cmd_cnt_o=1, busy_o=0.
REQ-031 The bench SHALL cover: three queued, flush_i pulsed during REQ -> level_o=0 on the next edge; the in-flight command completes and cmd_cnt_o increments by 1 only.
REQ-032 The bench SHALL cover: cmd_cnt_o=255 followed by one completed handshake -> cmd_cnt_o=0; reset asserted during REQ -> request low on the next edge.
